// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO with a valid/ready output
// stream, plus sticky framing and overrun error flags.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          wb_clk,
    input  logic                          wb_rst_n,
    input  logic                          i_rx,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_frame_err,
    output logic                          o_overrun,
    input  logic                          i_clr_err
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic              rx_meta;
    logic              rx_s;
    logic [1:0]        state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        rx_shift;

    logic              baud_last;
    logic              push_req;
    logic              stop_bad;
    logic              pop;
    logic              full;
    logic              push_ok;
    logic              drop;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_next;

    // Both flops reset to the idle level so releasing reset never looks like a start edge.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            rx_shift <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    if (!rx_s) begin
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt == BAUD_HALF) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    // Leave on the stop sample itself so a back-to-back start edge is not missed.
                    if (baud_last) begin
                        baud_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign push_req  = (state == ST_STOP) && baud_last && rx_s;
    assign stop_bad  = (state == ST_STOP) && baud_last && !rx_s;

    assign o_valid = (o_count != '0);
    assign pop     = o_valid && i_ready;
    assign full    = (o_count == CNT_FULL);
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;
    assign rd_next = rd_ptr + PTR_W'(1);

    // NOTE: the storage array has no reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge wb_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= rx_shift;
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_count <= '0;
            o_data  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            case ({push_ok, pop})
                2'b10:   o_count <= o_count + CNT_ONE;
                2'b01:   o_count <= o_count - CNT_ONE;
                default: o_count <= o_count;
            endcase
            // The head is registered: a byte landing in an empty (or emptying) FIFO goes straight out.
            if (push_ok && ((o_count == '0) || (pop && (o_count == CNT_ONE)))) begin
                o_data <= rx_shift;
            end else if (pop && (o_count > CNT_ONE)) begin
                o_data <= mem[rd_next];
            end
        end
    end

    // Set has priority over clear when both land on the same edge.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
        end else begin
            if (stop_bad) begin
                o_frame_err <= 1'b1;
            end else if (i_clr_err) begin
                o_frame_err <= 1'b0;
            end
            if (drop) begin
                o_overrun <= 1'b1;
            end else if (i_clr_err) begin
                o_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised and directed bench for uart_rx_fifo, checked against a queue-based model of
// the byte stream and the two sticky flags.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int FRAME = 10 * CPB;
    localparam int STOP_SAMPLE = 154;  // negedge index just before the stop-sample edge

    logic          wb_clk;
    logic          wb_rst_n;
    logic          i_rx;
    logic [7:0]    o_data;
    logic          o_valid;
    logic          i_ready;
    logic [CW-1:0] o_count;
    logic          o_frame_err;
    logic          o_overrun;
    logic          i_clr_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q[$];
    logic       ferr_m;
    logic       ovr_m;

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .wb_clk      (wb_clk),
        .wb_rst_n    (wb_rst_n),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_count     (o_count),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
        .i_clr_err   (i_clr_err)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Model of one received frame: good stop pushes or overflows, bad stop flags an error.
    task automatic model_frame(input logic [7:0] data, input logic stop);
        if (!stop) begin
            ferr_m = 1'b1;
        end else if (q.size() == DEPTH) begin
            ovr_m = 1'b1;
        end else begin
            q.push_back(data);
        end
    endtask

    task automatic check_state(input string tag);
        @(negedge wb_clk);
        check({tag, "_count"}, 32'(o_count), q.size());
        check({tag, "_valid"}, 32'(o_valid), 32'(q.size() != 0));
        check({tag, "_ferr"},  32'(o_frame_err), 32'(ferr_m));
        check({tag, "_ovr"},   32'(o_overrun), 32'(ovr_m));
        if (q.size() != 0) begin
            check({tag, "_head"}, 32'(o_data), 32'(q[0]));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge wb_clk);
            i_rx = 1'b1;
        end
    endtask

    task automatic pop_one(input string tag);
        @(negedge wb_clk);
        check({tag, "_valid"}, 32'(o_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check({tag, "_data"}, 32'(o_data), 32'(q[0]));
            i_ready = 1'b1;
            @(negedge wb_clk);
            i_ready = 1'b0;
            void'(q.pop_front());
        end
    endtask

    task automatic clr_err();
        @(negedge wb_clk);
        i_clr_err = 1'b1;
        @(negedge wb_clk);
        i_clr_err = 1'b0;
        ferr_m = 1'b0;
        ovr_m  = 1'b0;
    endtask

    // Drives one frame, one line level per falling edge. pop_at asserts i_ready for a single
    // cycle; abort_at drops reset mid-frame and returns early.
    task automatic send_frame(input logic [7:0] data, input logic stop, input int pop_at,
                              input bit lat_chk, input int abort_at);
        bit aborted = 1'b0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge wb_clk);
            if (i == abort_at) begin
                wb_rst_n = 1'b0;
                i_rx     = 1'b1;
                aborted  = 1'b1;
                break;
            end
            if (i < CPB)           i_rx = 1'b0;
            else if (i < 9 * CPB)  i_rx = data[(i / CPB) - 1];
            else                   i_rx = stop;
            if (lat_chk && i == STOP_SAMPLE) begin
                check("pre_push_valid", 32'(o_valid), 32'(q.size() != 0));
            end
            if (lat_chk && i == STOP_SAMPLE + 1) begin
                check("post_push_valid", 32'(o_valid), 32'd1);
                check("post_push_data", 32'(o_data), 32'(data));
            end
            if (i == pop_at) begin
                check("stop_pop_head", 32'(o_data), 32'(q[0]));
                i_ready = 1'b1;
            end
            if (i == pop_at + 1) begin
                i_ready = 1'b0;
            end
        end
        if (!aborted) begin
            if (pop_at >= 0) begin
                void'(q.pop_front());
            end
            model_frame(data, stop);
            if (!stop) begin
                idle(24);
            end
        end
    endtask

    initial begin
        logic [7:0] b2b [4];
        b2b = '{8'h00, 8'hFF, 8'h3C, 8'hC3};
        wb_rst_n  = 1'b0;
        i_rx      = 1'b1;
        i_ready   = 1'b0;
        i_clr_err = 1'b0;
        ferr_m    = 1'b0;
        ovr_m     = 1'b0;

        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_data",  32'(o_data),  32'd0);
        check("rst_ferr",  32'(o_frame_err), 32'd0);
        check("rst_ovr",   32'(o_overrun), 32'd0);
        repeat (3) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        idle(4);

        // Single frame with latency check, then one pop.
        send_frame(8'hA5, 1'b1, -1, 1'b1, -1);
        check_state("single");
        pop_one("single_pop");
        check_state("single_empty");

        // Back-to-back frames fill the FIFO exactly.
        foreach (b2b[k]) send_frame(b2b[k], 1'b1, -1, 1'b0, -1);
        check_state("b2b_full");

        // Overrun, clear, then push+pop at full.
        send_frame(8'h77, 1'b1, -1, 1'b0, -1);
        check_state("overrun");
        clr_err();
        check_state("overrun_clr");
        send_frame(8'h42, 1'b1, STOP_SAMPLE, 1'b0, -1);
        check_state("full_pushpop");
        repeat (DEPTH) pop_one("drain_b2b");
        check_state("drained");

        // Framing error, then a clean frame.
        send_frame(8'h5A, 1'b0, -1, 1'b0, -1);
        check_state("frame_err");
        send_frame(8'h11, 1'b1, -1, 1'b0, -1);
        check_state("after_ferr");
        pop_one("pop_11");
        clr_err();

        // Short low glitch must not start a frame.
        repeat (4) begin
            @(negedge wb_clk);
            i_rx = 1'b0;
        end
        idle(40);
        check_state("glitch");

        // Two bytes plus a frame error, then reset during data bit 3.
        send_frame(8'h96, 1'b1, -1, 1'b0, -1);
        send_frame(8'h3B, 1'b1, -1, 1'b0, -1);
        send_frame(8'hC0, 1'b0, -1, 1'b0, -1);
        check_state("pre_reset");
        send_frame(8'hE7, 1'b1, -1, 1'b0, CPB + 3 * CPB + CPB / 2);
        #1;
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_count", 32'(o_count), 32'd0);
        check("arst_data",  32'(o_data),  32'd0);
        check("arst_ferr",  32'(o_frame_err), 32'd0);
        check("arst_ovr",   32'(o_overrun), 32'd0);
        q.delete();
        ferr_m = 1'b0;
        ovr_m  = 1'b0;
        repeat (3) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        idle(4);
        check_state("post_reset");
        send_frame(8'h81, 1'b1, -1, 1'b0, -1);
        check_state("rx_81");

        // Push and pop together at count==1: the new byte becomes head, valid stays high.
        send_frame(8'h6E, 1'b1, STOP_SAMPLE, 1'b1, -1);
        check_state("one_pushpop");

        // Randomised traffic.
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            logic       s;
            int         pa;
            idle($urandom_range(0, 4));
            d  = 8'($urandom);
            s  = ($urandom_range(0, 5) != 0);
            pa = (q.size() != 0 && $urandom_range(0, 2) == 0) ? STOP_SAMPLE : -1;
            send_frame(d, s, pa, 1'b0, -1);
            check_state("rnd");
            repeat ($urandom_range(0, 2)) pop_one("rnd_pop");
            if ($urandom_range(0, 3) == 0) clr_err();
        end
        while (q.size() != 0) pop_one("final_drain");
        check_state("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
